bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master, one-slave arbiter for the core's single Wishbone-style memory port. Master 0 is the core `controller` (fetch, load and store), and master 1 is an auxiliary requester (boot loader or debug/DMA port). The block grants the shared bus to one master per transaction using round-robin priority. Completion (`ack` or timeout `err`) is routed back only to the owner. It sits between the `controller`/datapath and the memory/peripheral interconnect.

## Interface
Reset and clocking (already decided): one clock, `clk`; reset is `reset`, synchronous and active-high.

Parameters:
- `TIMEOUT`, default 255: number of granted cycles without `ack_i` before an error completion. Must be ≥ 2. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `m0_adr_i`, `m1_adr_i`  in  32  master address
- `m0_dat_i`, `m1_dat_i`  in  32  master write data
- `m0_sel_i`, `m1_sel_i`  in  4  byte selects
- `m0_we_i`, `m1_we_i`  in  1  command, `controller_pkg::READ`/`WRITE` encoding
- `m0_stb_i`, `m1_stb_i`  in  1  request, held high until completion
- `m0_ack_o`, `m1_ack_o`  out  1  transaction done
- `m0_err_o`, `m1_err_o`  out  1  transaction timed out
- `m0_dat_o`, `m1_dat_o`  out  32  read data (`dat_i` passthrough)
- `adr_o`  out  32  slave address
- `dat_o`  out  32  slave write data
- `sel_o`  out  4  slave byte selects
- `we_o`  out  1  slave command
- `stb_o`  out  1  slave strobe
- `cyc_o`  out  1  bus cycle active
- `dat_i`  in  32  slave read data
- `ack_i`  in  1  slave acknowledge
- `grant_o`  out  2  one-hot owner, for debug

## Operation
- States:
  - IDLE: nobody owns the bus.
  - GRANT: `owner` register is valid.
- IDLE behaviour:
  - One request: grant that master.
  - Both request: grant the master that is not `last_owner`.
  - No request: stay in IDLE.
  - On a grant, load `owner` and set `last_owner` to the new owner.
- GRANT behaviour:
  - `stb_o = cyc_o = 1`.
  - `adr_o`, `dat_o`, `sel_o` and `we_o` are muxed from the owner.
  - `mX_ack_o = ack_i` only for the owner. `dat_i` is fanned out to both `mX_dat_o`.
- Exits from GRANT:
  - `ack_i` high: go to IDLE.
  - Owner drops `stb` before `ack_i`: abort, go to IDLE, no ack/err to anyone.
  - A late `ack_i` arriving in IDLE is ignored and is not routed to any master.
- Outside GRANT:
  - `stb_o = cyc_o = 0`, and all `mX_ack_o`/`mX_err_o` are 0.
  - Address/data/select/`we` outputs carry master 0's values (deterministic, not X).
- Reset values:
  - State IDLE, `last_owner` = 1, so master 0 wins the first tie.
  - `stb_o = cyc_o = 0`, all acks/errs 0, `grant_o = 0`.
- Reset mid-transaction:
  - Ownership is dropped immediately.
  - `stb_o` is 0 in the cycle after the reset edge.

## Timing
- Arbitration is registered:
  - Request first seen high in cycle N (IDLE) gives `stb_o` high from cycle N+1.
  - `ack_i` in cycle M is combinationally visible on the owner's `mX_ack_o` in cycle M.
  - The bus is IDLE in cycle M+1.
- Minimum transaction: 2 cycles (grant cycle plus ack cycle). There is one dead IDLE cycle between back-to-back grants.
- Fairness: with both masters continuously requesting, grants alternate 0,1,0,1 and neither master waits more than one transaction.
- Requests arriving while the bus is in GRANT are held off. Masters keep `stb` high until they are granted.

## Configuration
Macro: `BUS_TIMEOUT_EN`.

Defined:
- A counter clears on each grant and increments every GRANT cycle without `ack_i`.
- In the `TIMEOUT`-th such cycle:
  - `mX_err_o` = 1 for the owner for one cycle, with `mX_ack_o` = 0.
  - Next state is IDLE.
- `ack_i` in that same cycle wins: normal ack, no err.
- Counter width is `$clog2(TIMEOUT+1)`.

Undefined:
- No counter exists, `mX_err_o` is tied 0, and a granted master waits indefinitely.

## Structure
- `bus_arbiter_pkg` holds:
  - state enum (IDLE, GRANT);
  - owner constants `OWNER_CORE = 1'b0`, `OWNER_AUX = 1'b1`;
  - default `TIMEOUT` constant.
- `we` encoding reuses `controller_pkg::READ`/`WRITE`.
- One sub-module: `bus_timeout_counter`, with clear, enable and `expired` ports, instantiated only under `BUS_TIMEOUT_EN`.

## Test plan
- Single master, single read:
  - Stimulus: `m0_stb_i` high at cycle 0 with `adr 0x0000_0100`; slave acks at cycle 3 with `dat_i = 0xDEAD_BEEF`.
  - Required: `stb_o` high in cycles 1–3; `m0_ack_o` only in cycle 3 with `m0_dat_o = 0xDEAD_BEEF`; `m1_ack_o` stays 0.
- Simultaneous requests after reset, both held:
  - Required: grants go to m0 first, then m1, then m0; `grant_o` sequence `01, 10, 01`; one IDLE cycle between grants.
- Aux write while core waits:
  - Stimulus: m1 is granted with `we = WRITE`, `adr 0x1000_0000`, `dat 0x55`, `sel 0xF`; m0 requests mid-transaction.
  - Required: slave sees m1's values only; m0 is granted in the cycle after m1's ack plus one IDLE cycle.
- Abort:
  - Stimulus: m0 drops `stb` in cycle 2 of its grant; `ack_i` pulses one cycle later.
  - Required: `stb_o` is 0 from the cycle after the drop; no `m0_ack_o` or `m1_ack_o`.
- Timeout (`BUS_TIMEOUT_EN`, `TIMEOUT` = 4):
  - Stimulus: m1 granted, slave never acks.
  - Required: `m1_err_o` pulses in the 4th granted cycle, then the bus is IDLE.
  - Repeat with `ack_i` in that 4th cycle: ack, no err.
- Reset mid-grant:
  - Stimulus: `reset` asserted during m0's grant.
  - Required: `stb_o = 0` and `grant_o = 0` in the next cycle; after release, a tie goes to m0.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-master memory-port arbiter.
// The command encoding matches controller_pkg READ/WRITE.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned SEL_W           = 4;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } bus_req_t;

  // Round-robin pick: a tie goes to whoever did not own the bus last.
  function automatic logic pick_owner(input logic m0_req, input logic m1_req,
                                      input logic last_owner);
    if (m0_req && m1_req) begin
      return ~last_owner;
    end
    return m1_req ? OWNER_AUX : OWNER_CORE;
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts granted cycles without an acknowledge; flags the TIMEOUT-th one.
module bus_timeout_counter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q holds the number of earlier waiting cycles, so this is the TIMEOUT-th.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the core's single memory port.
// Optional bus timeout error completion is enabled with BUS_TIMEOUT_EN.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic [DATA_W-1:0] m0_dat_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              we_o,
  output logic              stb_o,
  output logic              cyc_o,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              ack_i,
  output logic [1:0]        grant_o
);

  state_e   state_q, state_d;
  logic     owner_q, owner_d;
  logic     last_owner_q, last_owner_d;
  logic     owner_stb;
  logic     timeout_hit;
  bus_req_t m0_req, m1_req, bus_req;

  assign m0_req = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i};
  assign m1_req = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i};

  assign owner_stb = (owner_q == OWNER_AUX) ? m1_stb_i : m0_stb_i;

`ifdef BUS_TIMEOUT_EN
  logic to_clear;
  logic to_enable;

  // Counter restarts while idle, so every grant begins from zero.
  assign to_clear  = (state_q == ST_IDLE);
  assign to_enable = (state_q == ST_GRANT) && !ack_i;

  bus_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^32'(TIMEOUT);
  assign timeout_hit        = 1'b0;
`endif

  // State and ownership registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_CORE;
      last_owner_q <= OWNER_AUX;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Next-state: arbitrate in IDLE, release on ack, abort or timeout.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          state_d      = ST_GRANT;
          owner_d      = pick_owner(m0_stb_i, m1_stb_i, last_owner_q);
          last_owner_d = owner_d;
        end
      end
      ST_GRANT: begin
        if (ack_i || !owner_stb || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: master 0's payload is parked on the slave port while idle.
  always_comb begin
    bus_req  = m0_req;
    stb_o    = 1'b0;
    cyc_o    = 1'b0;
    grant_o  = 2'b00;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;
    if (state_q == ST_GRANT) begin
      stb_o = 1'b1;
      cyc_o = 1'b1;
      if (owner_q == OWNER_AUX) begin
        bus_req  = m1_req;
        grant_o  = 2'b10;
        m1_ack_o = ack_i;
        m1_err_o = timeout_hit;
      end else begin
        grant_o  = 2'b01;
        m0_ack_o = ack_i;
        m0_err_o = timeout_hit;
      end
    end
  end

  assign adr_o    = bus_req.adr;
  assign dat_o    = bus_req.dat;
  assign sel_o    = bus_req.sel;
  assign we_o     = bus_req.we;
  assign m0_dat_o = dat_i;
  assign m1_dat_o = dat_i;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_stb_i, m1_we_i, m1_stb_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic [31:0] adr_o, dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, cyc_o, ack_i;
  logic [1:0]  grant_o;

  bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o),
    .cyc_o(cyc_o), .dat_i(dat_i), .ack_i(ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Master request state as seen by the bench
  logic [31:0] req_adr[2];
  logic [31:0] req_dat[2];
  logic [3:0]  req_sel[2];
  logic        req_we[2];
  logic        req_stb[2];

  // Reference model: who owns the bus (-1 = nobody), last winner, cycles waited
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_wait  = 0;

  // Last sampled outputs, for directed checks
  logic        obs_stb, obs_ack0, obs_ack1, obs_err0, obs_err1, obs_we;
  logic [1:0]  obs_grant;
  logic [31:0] obs_adr, obs_dat, obs_m0dat;
  logic [3:0]  obs_sel;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void drive_ports();
    m0_adr_i = req_adr[0]; m0_dat_i = req_dat[0]; m0_sel_i = req_sel[0];
    m0_we_i  = req_we[0];  m0_stb_i = req_stb[0];
    m1_adr_i = req_adr[1]; m1_dat_i = req_dat[1]; m1_sel_i = req_sel[1];
    m1_we_i  = req_we[1];  m1_stb_i = req_stb[1];
  endfunction

  function automatic void set_req(input int i, input logic stb, input logic [31:0] adr,
                                  input logic [31:0] dat, input logic [3:0] sel, input logic we);
    req_stb[i] = stb; req_adr[i] = adr; req_dat[i] = dat; req_sel[i] = sel; req_we[i] = we;
  endfunction

  // One bus cycle: drive at negedge, check against model, advance model, clock.
  task automatic step(input logic rst, input logic ack, input logic [31:0] rdat);
    int         idx;
    logic       to_hit;
    logic [1:0] exp_ack, exp_err, exp_grant;
    drive_ports();
    reset = rst; ack_i = ack; dat_i = rdat;
    #1;
    obs_stb = stb_o; obs_grant = grant_o; obs_ack0 = m0_ack_o; obs_ack1 = m1_ack_o;
    obs_err0 = m0_err_o; obs_err1 = m1_err_o; obs_adr = adr_o; obs_dat = dat_o;
    obs_sel = sel_o; obs_we = we_o; obs_m0dat = m0_dat_o;

    idx    = (mdl_owner < 0) ? 0 : mdl_owner;
    to_hit = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_hit = (mdl_owner >= 0) && !ack && (mdl_wait == int'(TO) - 1);
`endif
    exp_ack = 2'b00; exp_err = 2'b00; exp_grant = 2'b00;
    if (mdl_owner >= 0) begin
      exp_ack[mdl_owner]   = ack;
      exp_err[mdl_owner]   = to_hit;
      exp_grant[mdl_owner] = 1'b1;
    end
    check_eq("stb_o", 64'(stb_o), 64'(mdl_owner >= 0));
    check_eq("cyc_o", 64'(cyc_o), 64'(mdl_owner >= 0));
    check_eq("grant_o", 64'(grant_o), 64'(exp_grant));
    check_eq("adr_o", 64'(adr_o), 64'(req_adr[idx]));
    check_eq("dat_o", 64'(dat_o), 64'(req_dat[idx]));
    check_eq("sel_o", 64'(sel_o), 64'(req_sel[idx]));
    check_eq("we_o", 64'(we_o), 64'(req_we[idx]));
    check_eq("ack_o", 64'({m1_ack_o, m0_ack_o}), 64'(exp_ack));
    check_eq("err_o", 64'({m1_err_o, m0_err_o}), 64'(exp_err));
    check_eq("m0_dat_o", 64'(m0_dat_o), 64'(rdat));
    check_eq("m1_dat_o", 64'(m1_dat_o), 64'(rdat));

    // A completed master drops its request
    if (mdl_owner >= 0 && (ack || to_hit)) req_stb[mdl_owner] = 1'b0;

    if (rst) begin
      mdl_owner = -1; mdl_last = 1; mdl_wait = 0;
    end else if (mdl_owner >= 0) begin
      if (ack || to_hit || !req_stb[mdl_owner]) mdl_owner = -1;
      else mdl_wait++;
    end else if (req_stb[0] || req_stb[1]) begin
      if (req_stb[0] && req_stb[1]) mdl_owner = 1 - mdl_last;
      else mdl_owner = req_stb[1] ? 1 : 0;
      mdl_last = mdl_owner;
      mdl_wait = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 32'h0, 32'h0, 4'h0, CMD_READ);
    drive_ports();
    reset = 1'b1; ack_i = 1'b0; dat_i = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 32'h0);
    check_eq("rst_stb", 64'(obs_stb), 64'd0);
    check_eq("rst_grant", 64'(obs_grant), 64'd0);

    // Single master read
    set_req(0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rd_c0_stb", 64'(obs_stb), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rd_c1_stb", 64'(obs_stb), 64'd1);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rd_c2_ack0", 64'(obs_ack0), 64'd0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF);
    check_eq("rd_c3_stb", 64'(obs_stb), 64'd1);
    check_eq("rd_c3_ack0", 64'(obs_ack0), 64'd1);
    check_eq("rd_c3_dat", 64'(obs_m0dat), 64'hDEAD_BEEF);
    check_eq("rd_c3_ack1", 64'(obs_ack1), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rd_c4_stb", 64'(obs_stb), 64'd0);

    // Simultaneous requests after reset alternate 0,1,0
    step(1'b1, 1'b0, 32'h0);
    set_req(0, 1'b1, 32'h0000_0200, 32'h11, 4'h1, CMD_READ);
    set_req(1, 1'b1, 32'h0000_0300, 32'h22, 4'h2, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rr_idle0", 64'(obs_grant), 64'b00);
    step(1'b0, 1'b1, 32'h1);
    check_eq("rr_g1", 64'(obs_grant), 64'b01);
    req_stb[0] = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    check_eq("rr_idle1", 64'(obs_grant), 64'b00);
    step(1'b0, 1'b1, 32'h2);
    check_eq("rr_g2", 64'(obs_grant), 64'b10);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rr_idle2", 64'(obs_grant), 64'b00);
    step(1'b0, 1'b1, 32'h3);
    check_eq("rr_g3", 64'(obs_grant), 64'b01);

    // Aux write while the core waits
    set_req(1, 1'b1, 32'h1000_0000, 32'h55, 4'hF, CMD_WRITE);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("aw_grant", 64'(obs_grant), 64'b10);
    check_eq("aw_adr", 64'(obs_adr), 64'h1000_0000);
    check_eq("aw_dat", 64'(obs_dat), 64'h55);
    check_eq("aw_sel", 64'(obs_sel), 64'hF);
    check_eq("aw_we", 64'(obs_we), 64'(CMD_WRITE));
    set_req(0, 1'b1, 32'h0000_2000, 32'hAA, 4'h3, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    check_eq("aw_hold_adr", 64'(obs_adr), 64'h1000_0000);
    step(1'b0, 1'b1, 32'h0);
    check_eq("aw_ack1", 64'(obs_ack1), 64'd1);
    check_eq("aw_ack0", 64'(obs_ack0), 64'd0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("aw_dead", 64'(obs_grant), 64'b00);
    step(1'b0, 1'b1, 32'h0);
    check_eq("aw_core_grant", 64'(obs_grant), 64'b01);
    check_eq("aw_core_adr", 64'(obs_adr), 64'h0000_2000);

    // Abort: core drops stb in its second granted cycle
    set_req(0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    req_stb[0] = 1'b0;
    step(1'b0, 1'b0, 32'h0);
    check_eq("ab_drop_stb", 64'(obs_stb), 64'd1);
    step(1'b0, 1'b1, 32'h0);
    check_eq("ab_after_stb", 64'(obs_stb), 64'd0);
    check_eq("ab_late_ack", 64'({obs_ack1, obs_ack0}), 64'd0);

`ifdef BUS_TIMEOUT_EN
    // Timeout, then timeout cycle overridden by ack
    for (int rep = 0; rep < 2; rep++) begin
      set_req(1, 1'b1, 32'h0000_0500, 32'h0, 4'hF, CMD_READ);
      step(1'b0, 1'b0, 32'h0);
      for (int g = 1; g < int'(TO); g++) begin
        step(1'b0, 1'b0, 32'h0);
        check_eq("to_wait_err", 64'(obs_err1), 64'd0);
      end
      step(1'b0, 1'(rep), 32'h0);
      check_eq("to_err1", 64'(obs_err1), 64'(rep == 0));
      check_eq("to_ack1", 64'(obs_ack1), 64'(rep == 1));
      step(1'b0, 1'b0, 32'h0);
      check_eq("to_idle", 64'(obs_stb), 64'd0);
    end
`endif

    // Reset mid-grant
    set_req(0, 1'b1, 32'h0000_0600, 32'h0, 4'hF, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    set_req(1, 1'b1, 32'h0000_0700, 32'h0, 4'hF, CMD_READ);
    step(1'b0, 1'b0, 32'h0);
    check_eq("rg_stb", 64'(obs_stb), 64'd0);
    check_eq("rg_grant", 64'(obs_grant), 64'd0);
    step(1'b0, 1'b1, 32'h0);
    check_eq("rg_tie", 64'(obs_grant), 64'b01);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      logic dropped;
      dropped = 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (!req_stb[i]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(i, 1'b1, $urandom, $urandom, 4'($urandom), 1'($urandom));
        end else if (mdl_owner == i && $urandom_range(0, 15) == 0) begin
          req_stb[i] = 1'b0;
          dropped    = 1'b1;
        end
      end
      step(1'($urandom_range(0, 99) == 0),
           !dropped && ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
